detector_arbiter: RTL and testbench

DETECTOR_ARBITER -- requirements
Module: detector_arbiter

---
 rtl/detector_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_detector_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/detector_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : detector_arbiter
//  Purpose  : Two-requester round-robin arbiter in front of a serial
//             "000" Moore detector. A granted 8-bit word is shifted MSB
//             first through the detector. The number of edges on which
//             the detector enters ID000 is reported with a one-cycle
//             done pulse.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   1  system clock, rising edge
//    reset    in   1  asynchronous reset, active low
//    req0     in   1  requester 0 request (held until gnt0)
//    data0    in   8  requester 0 word (sampled on the grant edge only)
//    req1     in   1  requester 1 request (held until gnt1)
//    data1    in   8  requester 1 word (sampled on the grant edge only)
//    gnt0     out  1  one-cycle grant pulse to requester 0
//    gnt1     out  1  one-cycle grant pulse to requester 1
//    busy     out  1  high while shifting and in the completion cycle
//    done     out  1  one-cycle completion pulse
//    done_id  out  1  requester index of the finished word (held)
//    count    out  4  detection count of the finished word (held)
//    y        out  1  detector Moore output, 1 iff detector is in ID000
// ============================================================================
module detector_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [7:0] data0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       busy,
  output logic       done,
  output logic       done_id,
  output logic [3:0] count,
  output logic       y
);

  // --------------------------------------------------------------------------
  // State encodings
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } ctrl_state_t;

  typedef enum logic [2:0] {
    D_START = 3'd0,
    D_ID1   = 3'd1,
    D_ID0   = 3'd2,
    D_ID00  = 3'd3,
    D_ID000 = 3'd4
  } det_state_t;

  localparam logic [2:0] LAST_BIT = 3'd7;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  ctrl_state_t state_q;
  det_state_t  det_q;
  logic [7:0]  word_q;     // captured word, shifted left so bit 7 is next
  logic [2:0]  bitcnt_q;   // index of the bit being fed, 0..7
  logic [3:0]  run_q;      // running detection count of the current word
  logic        last_q;     // requester granted most recently
  logic        cur_id_q;   // requester owning the word in progress
  logic        gnt0_q;
  logic        gnt1_q;
  logic        busy_q;
  logic        done_q;
  logic        done_id_q;
  logic [3:0]  count_q;
  logic        y_q;

  // --------------------------------------------------------------------------
  // Next-state values
  // --------------------------------------------------------------------------
  logic        sel_d;      // requester that would win a grant this edge
  logic        bit_d;      // serial bit presented to the detector
  det_state_t  det_d;      // detector state after consuming bit_d
  logic        hit_d;      // detector enters ID000 on this edge
  logic [3:0]  run_d;      // running count including this edge
  logic [2:0]  bitcnt_d;

  // Round robin: a lone request wins outright; on a tie the requester
  // that was not granted last wins.
  always_comb begin
    sel_d = 1'b0;
    if (req0 && req1) begin
      sel_d = ~last_q;
    end else if (req1) begin
      sel_d = 1'b1;
    end
  end

  assign bit_d = word_q[7];

  // Detector transition function. A 1 always restarts the zero run; zeros
  // alternate between ID00 and ID000 once three have been seen, so only
  // odd-length zero runs of three or more sit in ID000.
  always_comb begin
    det_d = det_q;
    if (bit_d) begin
      det_d = D_ID1;
    end else begin
      case (det_q)
        D_START: det_d = D_ID0;
        D_ID1:   det_d = D_ID0;
        D_ID0:   det_d = D_ID00;
        D_ID00:  det_d = D_ID000;
        D_ID000: det_d = D_ID00;
        default: det_d = D_START;
      endcase
    end
  end

  assign hit_d    = (det_d == D_ID000);
  // At most three hits fit in eight bits, so the 4-bit count cannot wrap.
  assign run_d    = run_q + {3'b000, hit_d};
  assign bitcnt_d = bitcnt_q + 3'd1;

  // --------------------------------------------------------------------------
  // Controller, detector and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      det_q     <= D_START;
      word_q    <= 8'h00;
      bitcnt_q  <= 3'd0;
      run_q     <= 4'd0;
      last_q    <= 1'b1;     // requester 0 wins the first tie
      cur_id_q  <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      count_q   <= 4'd0;
      y_q       <= 1'b0;
    end else begin
      // Grant and done are single-cycle pulses.
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      done_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          // Detector keeps its last state here, so y is left untouched.
          if (req0 || req1) begin
            state_q  <= ST_SHIFT;
            busy_q   <= 1'b1;
            gnt0_q   <= ~sel_d;
            gnt1_q   <= sel_d;
            last_q   <= sel_d;
            cur_id_q <= sel_d;
            word_q   <= sel_d ? data1 : data0;
            bitcnt_q <= 3'd0;
            run_q    <= 4'd0;
            det_q    <= D_START;
            y_q      <= 1'b0;
          end
        end

        ST_SHIFT: begin
          det_q  <= det_d;
          y_q    <= hit_d;
          word_q <= {word_q[6:0], 1'b0};
          run_q  <= run_d;
          if (bitcnt_q == LAST_BIT) begin
            // The eighth bit's hit is folded into the reported count.
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
            count_q   <= run_d;
            done_id_q <= cur_id_q;
          end else begin
            bitcnt_q <= bitcnt_d;
          end
        end

        ST_DONE: begin
          // Requests seen on this edge are ignored; a request still held
          // in IDLE is taken on the following edge.
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign count   = count_q;
  assign y       = y_q;

endmodule
`default_nettype wire

// File: tb/tb_detector_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_detector_arbiter
//  Purpose  : Self-checking bench for detector_arbiter. Directed vectors
//             from a table, a reset-abort sequence, then random words
//             checked against a zero-run-length reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_detector_arbiter;

  logic       clk;
  logic       reset;
  logic       req0;
  logic [7:0] data0;
  logic       req1;
  logic [7:0] data1;
  logic       gnt0;
  logic       gnt1;
  logic       busy;
  logic       done;
  logic       done_id;
  logic [3:0] count;
  logic       y;

  int checks = 0;
  int errors = 0;
  bit last_m;   // model of the round-robin pointer

  detector_arbiter dut (
    .clk     (clk),
    .reset   (reset),
    .req0    (req0),
    .data0   (data0),
    .req1    (req1),
    .data1   (data1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .count   (count),
    .y       (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    bit         r0;
    bit         r1;
    logic [7:0] d0;
    logic [7:0] d1;
    bit         exp_id;
    int         exp_cnt;
    bit         exp_y;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: the detector sits in ID000 exactly when the current run of
  // zeros (since the word start or the last 1) is odd and at least 3.
  function automatic int model_cnt(input logic [7:0] w);
    int z;
    int c;
    z = 0;
    c = 0;
    for (int i = 7; i >= 0; i--) begin
      if (w[i]) z = 0;
      else begin
        z++;
        if (z >= 3 && (z % 2) == 1) c++;
      end
    end
    return c;
  endfunction

  function automatic bit model_y(input logic [7:0] w);
    int z;
    z = 0;
    for (int i = 7; i >= 0; i--) begin
      if (w[i]) z = 0;
      else z++;
    end
    return (z >= 3 && (z % 2) == 1);
  endfunction

  function automatic bit model_sel(input bit r0, input bit r1, input bit last);
    if (r0 && r1) return ~last;
    return r1;
  endfunction

  // One full transaction. Called at a negedge while the DUT is idle; ends
  // at the negedge of the IDLE cycle following DONE.
  task automatic do_txn(input bit r0, input bit r1, input logic [7:0] d0,
                        input logic [7:0] d1, input bit exp_id,
                        input int exp_cnt, input bit exp_y, input string tag);
    int n;
    req0  = r0;
    req1  = r1;
    data0 = d0;
    data1 = d1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(gnt0 || gnt1) && n < 4);
    chk({tag, "_gnt_latency"}, n, 1);
    chk({tag, "_gnt0"}, gnt0, !exp_id);
    chk({tag, "_gnt1"}, gnt1, exp_id);
    chk({tag, "_busy_grant"}, busy, 1);
    // Requester releases; inputs then churn while busy to show they are
    // neither re-sampled nor granted.
    n = 0;
    do begin
      req0  = 1'($urandom);
      req1  = 1'($urandom);
      data0 = 8'($urandom);
      data1 = 8'($urandom);
      @(negedge clk);
      n++;
      if (gnt0 || gnt1) chk({tag, "_extra_gnt"}, {gnt1, gnt0}, 0);
    end while (!done && n < 12);
    chk({tag, "_done_latency"}, n, 8);
    chk({tag, "_done_id"}, done_id, exp_id);
    chk({tag, "_count"}, count, exp_cnt);
    chk({tag, "_y_done"}, y, exp_y);
    chk({tag, "_busy_done"}, busy, 1);
    @(negedge clk);
    chk({tag, "_idle"}, {busy, done, gnt0, gnt1}, 0);
    chk({tag, "_y_hold"}, y, exp_y);
    chk({tag, "_count_hold"}, count, exp_cnt);
    req0 = 1'b0;
    req1 = 1'b0;
    last_m = exp_id;
  endtask

  initial begin
    // Spec vectors and a tie sequence from reset (pointer starts at 1).
    tbl[0] = '{1, 1, 8'b00010000, 8'b10001000, 0, 2, 0};
    tbl[1] = '{1, 1, 8'b00010000, 8'b10001000, 1, 2, 1};
    tbl[2] = '{1, 1, 8'b10001000, 8'b00000000, 0, 2, 1};
    tbl[3] = '{1, 0, 8'b10001000, 8'h00,       0, 2, 1};
    tbl[4] = '{0, 1, 8'h55,       8'b00000000, 1, 3, 0};
    tbl[5] = '{0, 1, 8'h00,       8'hFF,       1, 0, 0};
    tbl[6] = '{1, 1, 8'b00000000, 8'hFF,       0, 3, 0};
    tbl[7] = '{1, 0, 8'b00000001, 8'h00,       0, 3, 0};
    tbl[8] = '{0, 1, 8'h00,       8'b10100000, 1, 2, 1};

    reset = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    data0 = 8'h00;
    data1 = 8'h00;
    last_m = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {gnt0, gnt1, busy, done, done_id, y}, 0);
    chk("reset_count", count, 0);
    req0 = 1'b1;
    req1 = 1'b1;
    @(negedge clk);
    chk("reset_ignores_req", {gnt0, gnt1, busy}, 0);
    req0 = 1'b0;
    req1 = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      do_txn(tbl[i].r0, tbl[i].r1, tbl[i].d0, tbl[i].d1,
             tbl[i].exp_id, tbl[i].exp_cnt, tbl[i].exp_y, $sformatf("vec%0d", i));
    end

    // Reset mid-SHIFT: grant, 4 bits in (detector in ID000), then abort.
    req0  = 1'b1;
    data0 = 8'b10001000;
    @(negedge clk);
    chk("abort_gnt0", gnt0, 1);
    req0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_y_before", y, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_async_outputs", {gnt0, gnt1, busy, done, done_id, y}, 0);
    chk("abort_async_count", count, 0);
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_done", {done, busy}, 0);
    end
    reset  = 1'b1;
    last_m = 1'b1;
    do_txn(0, 1, 8'hA5, 8'b00000000, 1, 3, 0, "post_reset");

    // Random words against the reference model.
    for (int i = 0; i < 40; i++) begin
      bit         r0;
      bit         r1;
      bit         s;
      logic [7:0] d0;
      logic [7:0] d1;
      logic [7:0] w;
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      if ((i % 8) == 0) d0 = 8'h00;
      s = model_sel(r0, r1, last_m);
      w = s ? d1 : d0;
      do_txn(r0, r1, d0, d1, s, model_cnt(w), model_y(w), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
